// File: rtl/serdes_tx_pkg.sv
// Shared constants for the serial transmitter: PRBS7 taps and seed, plus the idle clock-pattern polarity.
// Used by serdes_tx_serializer and serdes_tx_fifo.
package serdes_tx_pkg;

    localparam logic [6:0] PRBS7_DEFAULT_SEED = 7'h7F;
    localparam int         PRBS7_TAP_HI       = 6;
    localparam int         PRBS7_TAP_LO       = 5;

    // The first bit of an idle clock-pattern word; the following bits alternate from it.
    localparam logic       IDLE_FIRST_BIT     = 1'b1;

    // x^7 + x^6 + 1 in Fibonacci form; the output bit is the MSB.
    function automatic logic [6:0] prbs7_next(input logic [6:0] state);
        return {state[5:0], state[PRBS7_TAP_HI] ^ state[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/serdes_tx_fifo.sv
// Small synchronous word FIFO with push/pop, full/empty flags and an occupancy count.
// The head word is presented combinationally so that a pop lands directly in the shift register.
module serdes_tx_fifo
    import serdes_tx_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/serdes_tx_serializer.sv
// Parallel-to-serial transmitter: FIFO-buffered words shifted out one bit per clk, idle fill on underrun.
// Optional macro TX_PRBS_EN: idle bits come from a PRBS7 LFSR instead of the 1010 clock pattern.
module serdes_tx_serializer
    import serdes_tx_pkg::*;
#(
    parameter int         NBIT       = 10,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [6:0] PRBS_SEED  = PRBS7_DEFAULT_SEED
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NBIT-1:0]               din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          data,
    output logic                          word_start,
    output logic                          idle,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              CW       = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NBIT - 1);

    if (PRBS_SEED == 7'd0) begin : g_bad_seed
        $error("PRBS_SEED must be nonzero");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [CW-1:0]   cnt_reg,      cnt_next;
    logic [NBIT-1:0] shreg_reg,    shreg_next;
    logic            data_reg,     data_next;
    logic            ws_reg,       ws_next;
    logic            idle_reg,     idle_next;
    logic            underrun_reg, underrun_next;
    logic            accepted_reg, accepted_next;

    logic [NBIT-1:0] head;
    logic [NBIT-1:0] idle_word;
    logic [NBIT-1:0] word_src;
    logic            fifo_full;
    logic            fifo_empty;
    logic            load;
    logic            push;
    logic            pop;
    logic            idle_bit_now;

    assign load = (cnt_reg == CNT_LAST);
    assign push = din_valid && !fifo_full;
    assign pop  = load && !fifo_empty;

    serdes_tx_fifo #(
        .WIDTH (NBIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (rst),
        .wr_en   (push),
        .wr_data (din),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    function automatic logic first_bit(input logic [NBIT-1:0] w);
        return MSB_FIRST ? w[NBIT-1] : w[0];
    endfunction

    function automatic logic [NBIT-1:0] shift_out(input logic [NBIT-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

`ifdef TX_PRBS_EN
    // Idle bits bypass the shift register, so the idle word content is irrelevant.
    assign idle_word = '0;

    logic [6:0] lfsr_reg, lfsr_next;
`else
    // Alternating pattern laid out so that transmission position 0 carries IDLE_FIRST_BIT.
    for (genvar gi = 0; gi < NBIT; gi++) begin : g_idle_word
        assign idle_word[MSB_FIRST ? (NBIT - 1 - gi) : gi] =
            ((gi % 2) == 0) ? IDLE_FIRST_BIT : ~IDLE_FIRST_BIT;
    end
`endif

    assign word_src     = fifo_empty ? idle_word : head;
    assign idle_bit_now = load ? fifo_empty : idle_reg;

    always_comb begin
        cnt_next      = cnt_reg + CW'(1);
        shreg_next    = shift_out(shreg_reg);
        data_next     = first_bit(shreg_reg);
        ws_next       = 1'b0;
        idle_next     = idle_reg;
        underrun_next = underrun_reg;
        accepted_next = accepted_reg | push;
        if (load) begin
            cnt_next      = '0;
            shreg_next    = shift_out(word_src);
            data_next     = first_bit(word_src);
            ws_next       = 1'b1;
            idle_next     = fifo_empty;
            // A push on this same edge does not count as a prior acceptance.
            underrun_next = underrun_reg | (fifo_empty & accepted_reg);
        end
`ifdef TX_PRBS_EN
        lfsr_next = lfsr_reg;
        if (idle_bit_now) begin
            data_next = lfsr_reg[PRBS7_TAP_HI];
            lfsr_next = prbs7_next(lfsr_reg);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= CNT_LAST;
            shreg_reg    <= '0;
            data_reg     <= 1'b0;
            ws_reg       <= 1'b0;
            idle_reg     <= 1'b1;
            underrun_reg <= 1'b0;
            accepted_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            shreg_reg    <= shreg_next;
            data_reg     <= data_next;
            ws_reg       <= ws_next;
            idle_reg     <= idle_next;
            underrun_reg <= underrun_next;
            accepted_reg <= accepted_next;
        end
    end

`ifdef TX_PRBS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= PRBS_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    // Keeps the otherwise unused qualifier visible to lint in the clock-pattern build.
    logic unused_idle_bit;
    assign unused_idle_bit = idle_bit_now;
`endif

    assign din_ready  = !fifo_full;
    assign data       = data_reg;
    assign word_start = ws_reg;
    assign idle       = idle_reg;
    assign underrun   = underrun_reg;

endmodule
